// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with frame-synchronous word update
module seg7_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                load,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                hex_mode,
   input  logic                lzb,
   output logic [6:0]          seg,
   output logic                dp_out,
   output logic [DIGITS-1:0]   an,
   output logic                load_ack,
   output logic                frame_start
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int DW = $clog2(REFRESH_DIV);
   localparam int W  = 5*DIGITS;

   logic [DW-1:0] div;
   logic [IW-1:0] idx;
   logic [W-1:0]  shadow, disp, word;
   logic          pending, div_end, boundary, blank, dp_bit, zero;
   logic [3:0]    nib;
   logic [6:0]    seg_nx;

   function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
      case (n)
         4'h0:    return 7'b1111110;
         4'h1:    return 7'b0110000;
         4'h2:    return 7'b1101101;
         4'h3:    return 7'b1111001;
         4'h4:    return 7'b0110011;
         4'h5:    return 7'b1011011;
         4'h6:    return 7'b1011111;
         4'h7:    return 7'b1110000;
         4'h8:    return 7'b1111111;
         4'h9:    return 7'b1111011;
         4'hA:    return hex ? 7'b1110111 : 7'b0000000;
         4'hB:    return hex ? 7'b0011111 : 7'b0000000;
         4'hC:    return hex ? 7'b1001110 : 7'b0000000;
         4'hD:    return hex ? 7'b0111101 : 7'b0000000;
         4'hE:    return hex ? 7'b1001111 : 7'b0000000;
         default: return hex ? 7'b1000111 : 7'b0000000;
      endcase
   endfunction

   assign word     = {value, dp_in};
   assign div_end  = en && div == DW'(REFRESH_DIV-1);
   assign boundary = div_end && idx == IW'(DIGITS-1);

   // refresh divider and active-digit index, parked at zero while disabled
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         div <= '0;
         idx <= '0;
      end else if (!en) begin
         div <= '0;
         idx <= '0;
      end else begin
         div <= div_end ? '0 : div + 1'b1;
         if (div_end) idx <= idx == IW'(DIGITS-1) ? '0 : idx + 1'b1;
      end

   // capture loads into shadow; swap into disp only at the frame boundary (load on that edge bypasses)
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shadow   <= '0;
         disp     <= '0;
         pending  <= 1'b0;
         load_ack <= 1'b0;
      end else begin
         load_ack <= load;
         if (load) shadow <= word;
         if (boundary) disp <= load ? word : (pending ? shadow : disp);
         pending <= boundary ? 1'b0 : (pending | load);
      end

   // select active nibble and dp; blank when it and every more significant nibble are zero
   always_comb begin
      zero   = 1'b1;
      nib    = '0;
      blank  = 1'b0;
      dp_bit = 1'b0;
      for (int k = DIGITS-1; k >= 0; k--) begin
         zero = zero & (disp[DIGITS+4*k +: 4] == 4'd0);
         if (idx == IW'(k)) begin
            nib    = disp[DIGITS+4*k +: 4];
            blank  = lzb & zero & (k != 0);
            dp_bit = disp[k];
         end
      end
      seg_nx = blank ? 7'b0000000 : decode(nib, hex_mode);
   end

   // registered pin outputs, forced low while disabled
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         seg         <= '0;
         dp_out      <= 1'b0;
         an          <= '0;
         frame_start <= 1'b0;
      end else begin
         seg         <= en ? seg_nx : '0;
         dp_out      <= en & dp_bit;
         an          <= en ? DIGITS'(1) << idx : '0;
         frame_start <= en && div == '0 && idx == '0;
      end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed stimulus checked against a cycle-position model of the scanner
module tb_seg7_scan_driver;
   localparam int D  = 4;
   localparam int RD = 4;
   localparam int FR = D*RD;
   localparam logic [6:0] SEGTAB [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   logic          clk = 1'b0;
   logic          rst, en, load, hex_mode, lzb;
   logic [15:0]   value;
   logic [3:0]    dp_in;
   logic [6:0]    seg;
   logic          dp_out, load_ack, frame_start;
   logic [3:0]    an;
   int            errors = 0;
   int            checks = 0;

   seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
      .hex_mode(hex_mode), .lzb(lzb), .seg(seg), .dp_out(dp_out), .an(an),
      .load_ack(load_ack), .frame_start(frame_start));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
      end
   endtask

   // model: p = enabled edges since enable/reset; digit and boundary follow from p arithmetically
   int          p;
   int          dg;
   logic        bnd;
   logic [15:0] m_val, s_val;
   logic [3:0]  m_dp, s_dp, m_nib;
   logic        m_pend, m_blank;
   logic [6:0]  m_seg, e_seg;
   logic [3:0]  e_an;
   logic        e_dp, e_ack, e_fs;

   assign dg      = (p / RD) % D;
   assign bnd     = en && (p % FR == FR-1);
   assign m_nib   = 4'((m_val >> (4*dg)) & 16'hF);
   assign m_blank = lzb && dg != 0 && (m_val >> (4*dg)) == 16'd0;
   assign m_seg   = (m_blank || (m_nib > 9 && !hex_mode)) ? 7'b0 : SEGTAB[m_nib];

   always @(posedge clk or posedge rst)
      if (rst) begin
         p <= 0; m_val <= '0; s_val <= '0; m_dp <= '0; s_dp <= '0; m_pend <= 1'b0;
         e_seg <= '0; e_an <= '0; e_dp <= 1'b0; e_ack <= 1'b0; e_fs <= 1'b0;
      end else begin
         e_ack <= load;
         e_an  <= en ? 4'(1 << dg) : 4'b0;
         e_fs  <= en && (p % FR == 0);
         e_dp  <= en && m_dp[dg];
         e_seg <= en ? m_seg : 7'b0;
         p     <= en ? p + 1 : 0;
         if (load) begin s_val <= value; s_dp <= dp_in; end
         if (bnd && load) begin m_val <= value; m_dp <= dp_in; end
         else if (bnd && m_pend) begin m_val <= s_val; m_dp <= s_dp; end
         m_pend <= bnd ? 1'b0 : (m_pend | load);
      end

   // every-cycle comparison against the model
   always @(negedge clk)
      if (!rst) begin
         chk("seg", {1'b0, seg}, {1'b0, e_seg});
         chk("an", {4'b0, an}, {4'b0, e_an});
         chk("dp_out", {7'b0, dp_out}, {7'b0, e_dp});
         chk("load_ack", {7'b0, load_ack}, {7'b0, e_ack});
         chk("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
         chk("pending", {7'b0, dut.pending}, {7'b0, m_pend});
      end

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      load = 1'b1; value = v; dp_in = d;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_fs();
      int n = 0;
      @(negedge clk);
      while (!frame_start && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("fs_wait", {7'b0, frame_start}, 8'd1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; load = 1'b0; value = '0; dp_in = '0; hex_mode = 1'b0; lzb = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("lit_rst_an", {4'b0, an}, 8'b0001);
      chk("lit_rst_fs", {7'b0, frame_start}, 8'd1);
      chk("lit_rst_seg", {1'b0, seg}, 8'b01111110);
      repeat (4) @(negedge clk);
      chk("lit_an1", {4'b0, an}, 8'b0010);
      chk("lit_fs0", {7'b0, frame_start}, 8'd0);
      do_load(16'h1234, 4'b0000);
      chk("lit_ack", {7'b0, load_ack}, 8'd1);
      chk("lit_old_seg", {1'b0, seg}, 8'b01111110);
      @(negedge clk);
      chk("lit_ack_off", {7'b0, load_ack}, 8'd0);
      wait_fs();
      chk("lit_1234_d0", {1'b0, seg}, 8'b00110011);
      repeat (4) @(negedge clk);
      chk("lit_1234_d1", {1'b0, seg}, 8'b01111001);
      repeat (8) @(negedge clk);
      chk("lit_1234_an3", {4'b0, an}, 8'b1000);
      chk("lit_1234_d3", {1'b0, seg}, 8'b00110000);
      lzb = 1'b1;
      wait_fs();
      do_load(16'h00A0, 4'b0000);
      wait_fs();
      chk("lit_a0_d0", {1'b0, seg}, 8'b01111110);
      repeat (4) @(negedge clk);
      chk("lit_a0_d1_dec", {1'b0, seg}, 8'b0);
      repeat (4) @(negedge clk);
      chk("lit_a0_d2", {1'b0, seg}, 8'b0);
      hex_mode = 1'b1;
      repeat (4) @(negedge clk);
      chk("lit_a0_d3", {1'b0, seg}, 8'b0);
      wait_fs();
      repeat (4) @(negedge clk);
      chk("lit_a0_d1_hex", {1'b0, seg}, 8'b01110111);
      do_load(16'h0000, 4'b0100);
      wait_fs();
      chk("lit_z_d0", {1'b0, seg}, 8'b01111110);
      chk("lit_z_dp0", {7'b0, dp_out}, 8'd0);
      repeat (8) @(negedge clk);
      chk("lit_z_an2", {4'b0, an}, 8'b0100);
      chk("lit_z_dp2", {7'b0, dp_out}, 8'd1);
      chk("lit_z_d2", {1'b0, seg}, 8'b0);
      repeat (4) @(negedge clk);
      chk("lit_z_dp3", {7'b0, dp_out}, 8'd0);
      lzb = 1'b0;
      wait_fs();
      repeat (14) @(negedge clk);
      load = 1'b1; value = 16'h5678; dp_in = 4'b0000;
      @(negedge clk);
      load = 1'b0;
      chk("lit_bnd_an3", {4'b0, an}, 8'b1000);
      chk("lit_bnd_old", {1'b0, seg}, 8'b01111110);
      @(negedge clk);
      chk("lit_bnd_an0", {4'b0, an}, 8'b0001);
      chk("lit_bnd_new", {1'b0, seg}, 8'b01111111);
      chk("lit_bnd_pend", {7'b0, dut.pending}, 8'd0);
      repeat (2) @(negedge clk);
      do_load(16'h1111, 4'b0000);
      do_load(16'h2222, 4'b0000);
      chk("lit_ack_b2b", {7'b0, load_ack}, 8'd1);
      wait_fs();
      chk("lit_second_wins", {1'b0, seg}, 8'b01101101);
      repeat (5) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("lit_off_seg", {1'b0, seg}, 8'b0);
      chk("lit_off_an", {4'b0, an}, 8'b0);
      do_load(16'h0003, 4'b0000);
      repeat (20) @(negedge clk);
      chk("lit_off_wait", {4'b0, an}, 8'b0);
      en = 1'b1;
      @(negedge clk);
      chk("lit_on_an", {4'b0, an}, 8'b0001);
      chk("lit_on_fs", {7'b0, frame_start}, 8'd1);
      chk("lit_on_old", {1'b0, seg}, 8'b01101101);
      wait_fs();
      chk("lit_on_new", {1'b0, seg}, 8'b01111001);
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("lit_arst", {seg, dp_out}, 8'b0);
      chk("lit_arst_an", {2'b0, an, load_ack, frame_start}, 8'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("lit_rel_an", {4'b0, an}, 8'b0001);
      repeat (20) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of DIGITS common-cathode 7-segment digits, successor to the single-digit combinational converter. Captures a packed nibble word on a load handshake and applies it at frame boundaries only, so no frame shows a mix of old and new digits. Scans one digit at a time at a programmable refresh rate. Adds decimal/hex decoding, leading-zero blanking, per-digit decimal points and a global enable. Sits between the datapath and the board's shared segment/anode pins.

## Interface
- DIGITS, 4: number of digits scanned; legal 1..8.
- REFRESH_DIV, 1000: clock cycles each digit is held; legal ≥ 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  display enable; 0 forces all display outputs to 0.
- load  in  1  capture request for value/dp_in; sampled on each rising clk edge.
- value  in  4*DIGITS  packed nibbles; nibble k = value[4k+3:4k]; digit DIGITS-1 is the most significant.
- dp_in  in  DIGITS  decimal point per digit; bit k belongs to digit k.
- hex_mode  in  1  1 = decode 0-F; 0 = decode 0-9 and blank nibbles above 9.
- lzb  in  1  leading-zero blanking enable.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-high.
- dp_out  out  1  decimal point for the active digit, active-high.
- an  out  DIGITS  one-hot digit select, active-high.
- load_ack  out  1  one-cycle pulse acknowledging a capture.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.

## Operation
- Registers:
  - shadow: 4*DIGITS + DIGITS bits; holds the latest loaded value and dp_in.
  - disp: same width; holds the word currently on display.
  - pending: 1 bit; a loaded word is waiting for the frame boundary.
  - div counter: 0..REFRESH_DIV-1.
  - idx: 0..DIGITS-1; width max(1, clog2(DIGITS)).
- Scan:
  - div counter increments every cycle while en=1.
  - At REFRESH_DIV-1, div wraps to 0 and idx advances; idx DIGITS-1 wraps to 0.
- Frame boundary: the edge where div=REFRESH_DIV-1 and idx=DIGITS-1.
  - If pending=1: disp ← shadow and pending ← 0.
- Load: on an edge with load=1:
  - shadow ← {value, dp_in} and pending ← 1.
  - load_ack is high for the following cycle.
  - Back-to-back loads are all acked; the last one before the boundary wins.
- Load on the same edge as the frame boundary: disp ← new {value, dp_in} directly (bypass), shadow ← the same word, pending ← 0.
- Decode (nibble of disp at idx):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - hex_mode=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - hex_mode=0: nibbles 10-15 give 0000000.
- Leading-zero blanking (lzb=1):
  - Digit k gives seg=0000000 if nibbles k..DIGITS-1 of disp are all 0.
  - Digit 0 is never blanked.
  - dp_out and an are unaffected by blanking.
- Enable low:
  - div and idx are held at 0.
  - seg, dp_out, an, frame_start are 0.
  - load, shadow, pending and the frame boundary update still operate as specified, but no boundary occurs while en=0; a pending word waits.
- hex_mode and lzb are not latched; they take effect on the next registered output.

## Timing
- All outputs registered. Reset value of seg, dp_out, an, load_ack, frame_start, div, idx, shadow, disp, pending is 0.
- Display outputs lag (idx, disp) by one cycle:
  - an = 1<<idx.
  - seg = decode of the active nibble.
  - dp_out = disp dp bit at idx.
- frame_start is high in the same cycle that an = 1 (digit 0 active) following an idx wrap, or following en rising.
- After en 0→1 (or reset release with en=1):
  - First edge: an=…0001 and frame_start=1; div counts from 0.
  - Digit 0 then persists REFRESH_DIV cycles including that cycle.
- Full frame = DIGITS*REFRESH_DIV cycles.
- Loaded data is visible at most DIGITS*REFRESH_DIV+1 cycles after the load edge.
- Reset mid-frame: all registers clear immediately (asynchronous). A pending word is lost.

## Test plan
- Reset with en=1, REFRESH_DIV=4, DIGITS=4 → an sequence 0001,0010,0100,1000 each 4 cycles; frame_start every 16 cycles; seg=1111110 throughout.
- load value=16'h1234 mid-frame → load_ack next cycle; disp unchanged until the boundary. Next frame gives seg 0110011 (an=0001), 1111001, 1101101, 0110000 (an=1000).
- value=16'h00A0, hex_mode=0 then 1, lzb=1:
  - hex_mode=0: digits 3 and 2 blank, digit 1 = 0000000, digit 0 = 1111110.
  - hex_mode=1: digit 1 = 1110111.
- value=0, lzb=1, dp_in=4'b0100 → only digit 0 shows 1111110; dp_out=1 only while an=0100.
- Load on the exact boundary edge → new word on digit 0 in the very next cycle, pending=0. Two loads in one frame → only the second appears.
- en dropped mid-frame → outputs 0 next cycle. en re-raised → an=0001 and frame_start=1 one cycle later. Async rst mid-frame → all outputs 0 without a clock edge.
